// File: rtl/astack_seq.sv
// Stack operation sequencer: checks legality of stack requests against the tracked depth and
// issues one registered stack strobe per legal op. DROPN is expanded into a burst of POP strobes.
module astack_seq #(
    parameter int unsigned W  = 16,
    parameter int unsigned D  = 16,
    localparam int unsigned DW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [3:0]    req_arg,
    input  logic          err_clr,
    output logic          stk_cs,
    output logic [2:0]    stk_mode,
    output logic [2:0]    stk_dsel,
    output logic [DW-1:0] depth,
    output logic          empty,
    output logic          full,
    output logic          busy,
    output logic          err,
    output logic [1:0]    err_code
);

    // Common compare width so 4-bit arguments and the depth counter line up for any D.
    localparam int unsigned CW = (DW > 4) ? DW : 4;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_OVF  = 2'd1;
    localparam logic [1:0] ERR_UNF  = 2'd2;
    localparam logic [1:0] ERR_ARG  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_ERR} state_e;
    typedef enum logic [2:0] {
        OP_NOP, OP_PUSH, OP_POP, OP_REP1, OP_REP2, OP_POPREP, OP_BUB, OP_DROPN
    } op_e;

    // W only describes the operand width of the stack being driven; a zero width is meaningless.
    if (W == 0) begin : g_w_zero
    end

    state_e          state_q, state_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            cs_q, cs_d;
    logic [2:0]      mode_q, mode_d;
    logic [2:0]      dsel_q, dsel_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic [1:0]      code_q, code_d;
    logic            empty_q, empty_d;
    logic            full_q, full_d;

    op_e             op_c;
    logic            legal_c;
    logic [1:0]      fault_c;
    logic [CW-1:0]   arg_w, bub_w, dep_w;

    // Legality of the presented request against the current depth.
    always_comb begin
        op_c    = op_e'(req_op);
        arg_w   = CW'(req_arg);
        bub_w   = CW'(req_arg[2:0]);
        dep_w   = CW'(depth_q);
        legal_c = 1'b1;
        fault_c = ERR_NONE;
        unique case (op_c)
            OP_PUSH: begin
                legal_c = dep_w < CW'(D);
                fault_c = ERR_OVF;
            end
            OP_POP, OP_REP1: begin
                legal_c = dep_w >= CW'(1);
                fault_c = ERR_UNF;
            end
            OP_REP2, OP_POPREP: begin
                legal_c = dep_w >= CW'(2);
                fault_c = ERR_UNF;
            end
            OP_BUB: begin
                legal_c = bub_w < dep_w;
                fault_c = ERR_ARG;
            end
            OP_DROPN: begin
                legal_c = arg_w <= dep_w;
                fault_c = ERR_UNF;
            end
            default: begin
                legal_c = 1'b1;
                fault_c = ERR_NONE;
            end
        endcase
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        cnt_d   = cnt_q;
        cs_d    = 1'b0;
        mode_d  = 3'd0;
        dsel_d  = 3'd0;
        busy_d  = 1'b0;
        err_d   = err_q;
        code_d  = code_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (!legal_c) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        code_d  = fault_c;
                    end else if (op_c == OP_DROPN) begin
                        // The acceptance edge issues the first POP; DRAIN issues the rest.
                        if (req_arg != 4'd0) begin
                            cs_d    = 1'b1;
                            mode_d  = 3'(OP_POP);
                            busy_d  = 1'b1;
                            depth_d = depth_q - DW'(1);
                            if (req_arg != 4'd1) begin
                                state_d = S_DRAIN;
                                cnt_d   = req_arg - 4'd1;
                            end
                        end
                    end else if (op_c != OP_NOP) begin
                        cs_d   = 1'b1;
                        mode_d = req_op;
                        dsel_d = req_arg[2:0];
                        if (op_c == OP_PUSH) begin
                            depth_d = depth_q + DW'(1);
                        end else if (op_c == OP_POP || op_c == OP_POPREP) begin
                            depth_d = depth_q - DW'(1);
                        end
                    end
                end
            end
            S_DRAIN: begin
                cs_d    = 1'b1;
                mode_d  = 3'(OP_POP);
                busy_d  = 1'b1;
                depth_d = depth_q - DW'(1);
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                if (err_clr) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                    code_d  = ERR_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        empty_d = (depth_d == '0);
        full_d  = (CW'(depth_d) == CW'(D));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            depth_q <= '0;
            cnt_q   <= 4'd0;
            cs_q    <= 1'b0;
            mode_q  <= 3'd0;
            dsel_q  <= 3'd0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            mode_q  <= mode_d;
            dsel_q  <= dsel_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            code_q  <= code_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign stk_cs    = cs_q;
    assign stk_mode  = mode_q;
    assign stk_dsel  = dsel_q;
    assign depth     = depth_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign err_code  = code_q;

endmodule

// File: doc/astack_seq.md
ASTACK_SEQ -- requirements
Module: astack_seq

Interface
REQ-001 SHALL have parameter W, default 16: operand width of the sequenced stack (informational; no data flows through this block).
REQ-002 SHALL have parameter D, default 16: stack depth in entries; DW = clog2(D+1).
REQ-003 SHALL have port clk  in  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1: reset, asynchronous assertion, active-low.
REQ-005 SHALL have port req_valid  in  1: operation request present.
REQ-006 SHALL have port req_ready  out  1: sequencer can accept a request this cycle.
REQ-007 SHALL have port req_op  in  3: 0 NOP, 1 PUSH, 2 POP, 3 REP1, 4 REP2, 5 POPREP, 6 BUB, 7 DROPN.
REQ-008 SHALL have port req_arg  in  4: BUB select index (bits 2:0) or DROPN count (bits 3:0).
REQ-009 SHALL have port err_clr  in  1: clears the error state.
REQ-010 SHALL have port stk_cs  out  1: stack update strobe.
REQ-011 SHALL have port stk_mode  out  3: stack mode, same encoding as req_op for codes 0-6.
REQ-012 SHALL have port stk_dsel  out  3: stack second-read and BUB select.
REQ-013 SHALL have port depth  out  DW: current number of valid entries.
REQ-014 SHALL have ports empty, full  out  1 each: depth==0, depth==D.
REQ-015 SHALL have ports busy  out  1 and err  out  1: DROPN in progress; sticky error.
REQ-016 SHALL have port err_code  out  2: 0 none, 1 overflow, 2 underflow, 3 bad argument.

Function
REQ-017 SHALL implement FSM states IDLE, DRAIN, ERR; req_ready = (state==IDLE), combinational.
REQ-018 SHALL accept a request on a rising edge with req_valid & req_ready.
REQ-019 SHALL check legality at acceptance: PUSH needs depth<D; POP, REP1 need depth>=1; REP2, POPREP need depth>=2; BUB needs arg[2:0]<depth; DROPN needs arg<=depth.
REQ-020 SHALL, for a legal op 1-6, drive stk_cs=1, stk_mode=req_op, stk_dsel=arg[2:0] for exactly the one cycle following acceptance (registered; latency 1).
REQ-021 SHALL update depth on the acceptance edge: PUSH +1; POP, POPREP -1; REP1, REP2, BUB unchanged.
REQ-022 SHALL treat NOP and DROPN with arg=0 as accepted with no stk_cs pulse and no depth change.
REQ-023 SHALL, for a legal DROPN arg=N>=1, enter DRAIN; stk_cs=1 with stk_mode=POP for N consecutive cycles; depth -1 per pulse; busy=1 throughout DRAIN; return to IDLE on the edge issuing the last pulse.
REQ-024 SHALL, for an illegal request, issue no stk_cs, set err=1 and err_code (overflow for PUSH; underflow for POP/REP1/REP2/POPREP/DROPN; bad argument for BUB), and enter ERR; depth unchanged.
REQ-025 SHALL, in ERR, hold req_ready=0 and ignore req_valid; err_clr=1 returns to IDLE next edge with err=0, err_code=0.
REQ-026 SHALL ignore err_clr outside ERR; err_clr and req_valid in the same ERR cycle SHALL NOT accept the request.
REQ-027 SHALL allow back-to-back acceptance every cycle in IDLE, producing a continuous stk_cs stream.
REQ-028 SHALL drive stk_cs=0, stk_mode=0 on every cycle with no issued op.

Reset
REQ-029 SHALL, while rst=0, force state IDLE, depth=0, stk_cs=0, stk_mode=0, stk_dsel=0, busy=0, err=0, err_code=0, immediately and independent of clk.
REQ-030 SHALL abort any DRAIN in progress on reset, with no further stk_cs pulses.

Verification
REQ-031 SHALL cover: reset, 16 PUSH -> depth=16, full=1, 16 stk_cs pulses; 17th PUSH -> no pulse, err=1, err_code=1, req_ready=0.
REQ-032 SHALL cover: reset, POP -> err_code=2, depth=0; err_clr -> next cycle err=0, req_ready=1.
REQ-033 SHALL cover: depth=5, DROPN arg=3 -> 3 consecutive stk_cs pulses with mode=2, busy=1 for 3 cycles, depth=2, req_ready=1 on the 4th cycle.
REQ-034 SHALL cover: depth=4, BUB arg=2 -> one pulse with mode=6, dsel=2, depth=4; BUB arg=5 -> err_code=3.
REQ-035 SHALL cover: rst=0 mid-DROPN (arg=8, after 3 pulses) -> stk_cs=0, depth=0 asynchronously; no pulses after release.
REQ-036 SHALL cover: PUSH accepted on 4 consecutive cycles -> stk_cs high 4 consecutive cycles, depth=4.
